// File: rtl/bcd_rtc_clock.sv
// BCD HH:MM:SS time-of-day counter with seconds prescaler, validated loading,
// 12/24-hour display conversion, latched alarm and day-rollover pulse.
module bcd_rtc_clock #(
    parameter int CLK_DIV = 100_000_000,
    parameter int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic        CLK,
    input  logic        Reset_time,
    input  logic        Set_time,
    input  logic [23:0] Time_in,
    input  logic        Alarm_set,
    input  logic [23:0] Alarm_in,
    input  logic        Alarm_en,
    input  logic        Alarm_clr,
    input  logic        Mode_12h,
    output logic [23:0] Time_out,
    output logic        PM,
    output logic        Tick,
    output logic        Day_pulse,
    output logic        Alarm_flag,
    output logic        Set_err
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [23:0]      curTime_q, curTime_d;
    logic [23:0]      alarmTime_q, alarmTime_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             dayPulse_q, dayPulse_d;
    logic             alarmFlag_q, alarmFlag_d;
    logic             setErr_q, setErr_d;

    logic             tickInt;
    logic             setValid;
    logic             alarmValid;
    logic [23:0]      nextTime;
    logic [3:0]       dispHh, dispHl;

    function automatic logic timeValid(input logic [23:0] t);
        logic [3:0] hh, hl, mh, ml, sh, sl;
        {hh, hl, mh, ml, sh, sl} = t;
        return (hh <= 4'd2) && (hl <= 4'd9) && !((hh == 4'd2) && (hl > 4'd3)) &&
               (mh <= 4'd5) && (ml <= 4'd9) && (sh <= 4'd5) && (sl <= 4'd9);
    endfunction

    function automatic logic [23:0] advanceTime(input logic [23:0] t);
        logic [3:0] hh, hl, mh, ml, sh, sl;
        {hh, hl, mh, ml, sh, sl} = t;
        if (sl != 4'd9) begin
            sl = sl + 4'd1;
        end else begin
            sl = 4'd0;
            if (sh != 4'd5) begin
                sh = sh + 4'd1;
            end else begin
                sh = 4'd0;
                if (ml != 4'd9) begin
                    ml = ml + 4'd1;
                end else begin
                    ml = 4'd0;
                    if (mh != 4'd5) begin
                        mh = mh + 4'd1;
                    end else begin
                        mh = 4'd0;
                        if ((hh == 4'd2) && (hl == 4'd3)) begin
                            hh = 4'd0;
                            hl = 4'd0;
                        end else if (hl == 4'd9) begin
                            hh = hh + 4'd1;
                            hl = 4'd0;
                        end else begin
                            hl = hl + 4'd1;
                        end
                    end
                end
            end
        end
        return {hh, hl, mh, ml, sh, sl};
    endfunction

    // A valid load wins over a coincident tick; a rejected load lets the tick through.
    always_comb begin
        tickInt     = (div_q == DIV_LAST);
        setValid    = Set_time && timeValid(Time_in);
        alarmValid  = Alarm_set && timeValid(Alarm_in);
        nextTime    = advanceTime(curTime_q);
        curTime_d   = curTime_q;
        div_d       = tickInt ? '0 : div_q + 1'b1;
        tick_d      = 1'b0;
        dayPulse_d  = 1'b0;
        alarmTime_d = alarmValid ? Alarm_in : alarmTime_q;
        alarmFlag_d = alarmFlag_q;
        setErr_d    = (Set_time && !setValid) || (Alarm_set && !alarmValid);
        if (setValid) begin
            curTime_d = Time_in;
            div_d     = '0;
        end else if (tickInt) begin
            curTime_d  = nextTime;
            tick_d     = 1'b1;
            dayPulse_d = (curTime_q == 24'h235959);
        end
        if (Alarm_clr) begin
            alarmFlag_d = 1'b0;
        end
        if (!setValid && tickInt && Alarm_en && (nextTime == alarmTime_q)) begin
            alarmFlag_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset_time) begin
        if (Reset_time) begin
            curTime_q   <= '0;
            alarmTime_q <= '0;
            div_q       <= '0;
            tick_q      <= 1'b0;
            dayPulse_q  <= 1'b0;
            alarmFlag_q <= 1'b0;
            setErr_q    <= 1'b0;
        end else begin
            curTime_q   <= curTime_d;
            alarmTime_q <= alarmTime_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            dayPulse_q  <= dayPulse_d;
            alarmFlag_q <= alarmFlag_d;
            setErr_q    <= setErr_d;
        end
    end

    // 12-hour view: 00 shows as 12, 13..23 drop by twelve with a BCD borrow.
    always_comb begin
        dispHh = curTime_q[23:20];
        dispHl = curTime_q[19:16];
        if (Mode_12h) begin
            if (curTime_q[23:16] == 8'h00) begin
                dispHh = 4'd1;
                dispHl = 4'd2;
            end else if (curTime_q[23:20] == 4'd2) begin
                if (curTime_q[19:16] >= 4'd2) begin
                    dispHh = 4'd1;
                    dispHl = curTime_q[19:16] - 4'd2;
                end else begin
                    dispHh = 4'd0;
                    dispHl = curTime_q[19:16] + 4'd8;
                end
            end else if ((curTime_q[23:20] == 4'd1) && (curTime_q[19:16] >= 4'd3)) begin
                dispHh = 4'd0;
                dispHl = curTime_q[19:16] - 4'd2;
            end
        end
    end

    assign Time_out   = {dispHh, dispHl, curTime_q[15:0]};
    assign PM         = (curTime_q[23:20] == 4'd2) ||
                        ((curTime_q[23:20] == 4'd1) && (curTime_q[19:16] >= 4'd2));
    assign Tick       = tick_q;
    assign Day_pulse  = dayPulse_q;
    assign Alarm_flag = alarmFlag_q;
    assign Set_err    = setErr_q;

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// Directed bench for bcd_rtc_clock: one instance with a 4-cycle prescaler and
// one ticking every cycle, both driven from the same stimulus.
module tb_bcd_rtc_clock;

    logic        CLK = 1'b0;
    logic        Reset_time;
    logic        Set_time;
    logic [23:0] Time_in;
    logic        Alarm_set;
    logic [23:0] Alarm_in;
    logic        Alarm_en;
    logic        Alarm_clr;
    logic        Mode_12h;

    logic [23:0] time4, time1;
    logic        pm4, pm1, tick4, tick1, day4, day1;
    logic        flag4, flag1, err4, err1;

    int assertCount = 0;
    int failCount   = 0;

    always #5 CLK = ~CLK;

    bcd_rtc_clock #(.CLK_DIV(4)) dut4 (
        .CLK(CLK), .Reset_time(Reset_time), .Set_time(Set_time), .Time_in(Time_in),
        .Alarm_set(Alarm_set), .Alarm_in(Alarm_in), .Alarm_en(Alarm_en),
        .Alarm_clr(Alarm_clr), .Mode_12h(Mode_12h), .Time_out(time4), .PM(pm4),
        .Tick(tick4), .Day_pulse(day4), .Alarm_flag(flag4), .Set_err(err4)
    );

    bcd_rtc_clock #(.CLK_DIV(1)) dut1 (
        .CLK(CLK), .Reset_time(Reset_time), .Set_time(Set_time), .Time_in(Time_in),
        .Alarm_set(Alarm_set), .Alarm_in(Alarm_in), .Alarm_en(Alarm_en),
        .Alarm_clr(Alarm_clr), .Mode_12h(Mode_12h), .Time_out(time1), .PM(pm1),
        .Tick(tick1), .Day_pulse(day1), .Alarm_flag(flag1), .Set_err(err1)
    );

    // Advance one rising edge and land 1 time unit after it.
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] observed,
                               input logic [23:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        Reset_time = 1'b1;
        Set_time   = 1'b0;
        Time_in    = '0;
        Alarm_set  = 1'b0;
        Alarm_in   = '0;
        Alarm_en   = 1'b0;
        Alarm_clr  = 1'b0;
        Mode_12h   = 1'b0;

        applyStimulus();
        applyStimulus();
        checkOutput("rst_time", time4, 24'h000000);
        checkOutput("rst_pm", pm4, 0);
        checkOutput("rst_tick", tick4, 0);
        checkOutput("rst_day", day4, 0);
        checkOutput("rst_flag", flag4, 0);
        checkOutput("rst_err", err4, 0);
        Mode_12h = 1'b1;
        #1;
        checkOutput("rst_time12", time4, 24'h120000);
        Mode_12h = 1'b0;

        applyStimulus();
        Reset_time = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus();
            checkOutput($sformatf("div4_tick_e%0d", i), tick4, (i % 4 == 0) ? 24'd1 : 24'd0);
        end
        checkOutput("div4_time12", time4, 24'h000003);

        Set_time = 1'b1;
        Time_in  = 24'h235958;
        applyStimulus();
        Set_time = 1'b0;
        checkOutput("wrap_load", time1, 24'h235958);
        checkOutput("wrap_load_tick", tick1, 0);
        checkOutput("wrap_load_pm", pm1, 1);
        applyStimulus();
        checkOutput("wrap_59", time1, 24'h235959);
        checkOutput("wrap_59_day", day1, 0);
        checkOutput("wrap_59_tick", tick1, 1);
        applyStimulus();
        checkOutput("wrap_00", time1, 24'h000000);
        checkOutput("wrap_00_day", day1, 1);
        checkOutput("wrap_00_pm", pm1, 0);
        applyStimulus();
        checkOutput("wrap_01", time1, 24'h000001);
        checkOutput("wrap_01_day", day1, 0);

        Set_time = 1'b1;
        Time_in  = 24'h245000;
        applyStimulus();
        checkOutput("bad_hour_err", err1, 1);
        checkOutput("bad_hour_time", time1, 24'h000002);
        Time_in = 24'h126000;
        applyStimulus();
        Set_time = 1'b0;
        checkOutput("bad_min_err", err1, 1);
        checkOutput("bad_min_time", time1, 24'h000003);
        Alarm_set = 1'b1;
        Alarm_in  = 24'h076000;
        applyStimulus();
        Alarm_set = 1'b0;
        checkOutput("bad_alarm_err", err1, 1);
        checkOutput("bad_alarm_time", time1, 24'h000004);
        applyStimulus();
        checkOutput("err_clear", err1, 0);
        checkOutput("err_clear_time", time1, 24'h000005);

        Mode_12h = 1'b1;
        Set_time = 1'b1;
        Time_in  = 24'h000000;
        applyStimulus();
        checkOutput("m12_midnight", time1, 24'h120000);
        checkOutput("m12_midnight_pm", pm1, 0);
        Time_in = 24'h130545;
        applyStimulus();
        Set_time = 1'b0;
        checkOutput("m12_13h", time1, 24'h010545);
        checkOutput("m12_13h_pm", pm1, 1);
        applyStimulus();
        checkOutput("m12_count", time1, 24'h010546);
        Mode_12h = 1'b0;
        #1;
        checkOutput("m24_toggle", time1, 24'h130546);
        applyStimulus();
        checkOutput("m24_count", time1, 24'h130547);

        Alarm_en  = 1'b1;
        Alarm_set = 1'b1;
        Alarm_in  = 24'h070000;
        Set_time  = 1'b1;
        Time_in   = 24'h065959;
        applyStimulus();
        Alarm_set = 1'b0;
        Set_time  = 1'b0;
        checkOutput("alarm_armed", flag1, 0);
        applyStimulus();
        checkOutput("alarm_hit_time", time1, 24'h070000);
        checkOutput("alarm_hit", flag1, 1);
        applyStimulus();
        checkOutput("alarm_sticky", flag1, 1);
        Set_time = 1'b1;
        Time_in  = 24'h065959;
        applyStimulus();
        Set_time  = 1'b0;
        Alarm_clr = 1'b1;
        applyStimulus();
        checkOutput("alarm_set_beats_clr", flag1, 1);
        applyStimulus();
        Alarm_clr = 1'b0;
        checkOutput("alarm_cleared", flag1, 0);
        Set_time = 1'b1;
        Time_in  = 24'h070000;
        applyStimulus();
        Set_time = 1'b0;
        checkOutput("alarm_load_time", time1, 24'h070000);
        checkOutput("alarm_load_noflag", flag1, 0);
        applyStimulus();
        checkOutput("alarm_load_after", flag1, 0);

        applyStimulus();
        Reset_time = 1'b1;
        #1;
        checkOutput("midrst_time4", time4, 24'h000000);
        checkOutput("midrst_time1", time1, 24'h000000);
        checkOutput("midrst_pm1", pm1, 0);
        checkOutput("midrst_tick1", tick1, 0);
        Mode_12h = 1'b1;
        #1;
        checkOutput("midrst_time12", time1, 24'h120000);
        Mode_12h = 1'b0;
        applyStimulus();
        Reset_time = 1'b0;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        Set_time = 1'b1;
        Time_in  = 24'h105030;
        applyStimulus();
        Set_time = 1'b0;
        checkOutput("settick_time", time4, 24'h105030);
        checkOutput("settick_notick", tick4, 0);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("settick_hold", time4, 24'h105030);
        applyStimulus();
        checkOutput("settick_next", time4, 24'h105031);
        checkOutput("settick_next_tick", tick4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
